// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU/shift/move/link results, HI/LO, single-cycle multiplier
// and a 32-step radix-2 divider FSM. Define EX_MADD_EN to add MADD/MADDU/MSUB/MSUBU.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_aluop,
  input  logic [2:0]  ex_alusel,
  input  logic [31:0] ex_opv1,
  input  logic [31:0] ex_opv2,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_link_addr,
  input  logic        ex_cur_in_delay_slot,
  output logic        mem_we,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_cur_in_delay_slot,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT = 8'h2A, OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ACC} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic [31:0] op_r, a_abs, b_abs;
  logic        known, is_div, is_madd, sgn, sgn_mul;
  logic [32:0] trial;
  logic [63:0] prod;
`ifdef EX_MADD_EN
  localparam logic [7:0] OP_MADD = 8'hA6, OP_MADDU = 8'hA7, OP_MSUB = 8'hAA, OP_MSUBU = 8'hAB;
  logic [63:0] tmp_q, tmp_d;
  assign is_madd = ex_aluop inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign sgn_mul = ex_aluop inside {OP_MULT, OP_MADD, OP_MSUB};
`else
  assign is_madd = 1'b0;
  assign sgn_mul = ex_aluop == OP_MULT;
`endif
  assign is_div = ex_aluop inside {OP_DIV, OP_DIVU};
  assign sgn = ex_aluop == OP_DIV;
  assign prod = sgn_mul ? {{32{ex_opv1[31]}}, ex_opv1} * {{32{ex_opv2[31]}}, ex_opv2}
                        : {32'b0, ex_opv1} * {32'b0, ex_opv2};
  assign a_abs = (sgn & ex_opv1[31]) ? -ex_opv1 : ex_opv1;
  assign b_abs = (sgn & ex_opv2[31]) ? -ex_opv2 : ex_opv2;
  assign trial = {rem_q, quot_q[31]} - {1'b0, dvs_q};
  assign stall_req = rst & (((state_q == IDLE) & (is_div | is_madd)) | (state_q == BUSY));
  assign mem_we = rst & ex_we & known & ~stall_req & ~is_madd;
  assign mem_waddr = rst ? ex_waddr : '0;
  assign mem_cur_in_delay_slot = rst & ex_cur_in_delay_slot;
  assign mem_wdata = (!rst || !known) ? '0 : (ex_alusel == 3'd5) ? ex_link_addr :
                     (ex_alusel != 3'd0 && ex_alusel <= 3'd4) ? op_r : '0;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  // per-opcode result and recognition of the supported opcode set
  always_comb begin
    op_r = '0;
    known = 1'b1;
    case (ex_aluop)
      OP_AND:  op_r = ex_opv1 & ex_opv2;
      OP_OR:   op_r = ex_opv1 | ex_opv2;
      OP_XOR:  op_r = ex_opv1 ^ ex_opv2;
      OP_NOR:  op_r = ~(ex_opv1 | ex_opv2);
      OP_SLL:  op_r = ex_opv2 << ex_opv1[4:0];
      OP_SRL:  op_r = ex_opv2 >> ex_opv1[4:0];
      OP_SRA:  op_r = $unsigned($signed(ex_opv2) >>> ex_opv1[4:0]);
      OP_ADDU: op_r = ex_opv1 + ex_opv2;
      OP_SUBU: op_r = ex_opv1 - ex_opv2;
      OP_SLT:  op_r = {31'b0, $signed(ex_opv1) < $signed(ex_opv2)};
      OP_SLTU: op_r = {31'b0, ex_opv1 < ex_opv2};
      OP_MFHI: op_r = hi_q;
      OP_MFLO: op_r = lo_q;
      OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_r = '0;
`ifdef EX_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_r = '0;
`endif
      default: known = 1'b0;
    endcase
  end
  // divider/accumulate sequencing and HI/LO write selection
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`ifdef EX_MADD_EN
    tmp_d = tmp_q;
`endif
    case (state_q)
      IDLE: begin
        if (is_div) begin
          dvs_d = b_abs;
          quot_d = (b_abs == '0) ? '1 : a_abs;
          rem_d = (b_abs == '0) ? a_abs : '0;
          qneg_d = sgn & (ex_opv1[31] ^ ex_opv2[31]) & (b_abs != '0);
          rneg_d = sgn & ex_opv1[31];
          cnt_d = '0;
          state_d = (b_abs == '0) ? DONE : BUSY;
        end
`ifdef EX_MADD_EN
        else if (is_madd) begin
          tmp_d = prod;
          state_d = ACC;
        end
`endif
        else if (ex_aluop == OP_MTHI) hi_d = ex_opv1;
        else if (ex_aluop == OP_MTLO) lo_d = ex_opv1;
        else if (ex_aluop inside {OP_MULT, OP_MULTU}) {hi_d, lo_d} = prod;
      end
      BUSY: begin
        quot_d = {quot_q[30:0], ~trial[32]};
        rem_d = trial[32] ? {rem_q[30:0], quot_q[31]} : trial[31:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DONE;
      end
      DONE: begin
        hi_d = rneg_q ? -rem_q : rem_q;
        lo_d = qneg_q ? -quot_q : quot_q;
        state_d = IDLE;
      end
      default: begin
`ifdef EX_MADD_EN
        {hi_d, lo_d} = (ex_aluop inside {OP_MSUB, OP_MSUBU}) ? {hi_q, lo_q} - tmp_q : {hi_q, lo_q} + tmp_q;
`endif
        state_d = IDLE;
      end
    endcase
  end
  // state registers; reset abandons an in-flight divide and clears HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`ifdef EX_MADD_EN
      tmp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`ifdef EX_MADD_EN
      tmp_q <= tmp_d;
`endif
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against an arithmetic reference model
module tb_ex_stage;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  aluop = '0;
  logic [2:0]  alusel = '0;
  logic [31:0] opv1 = '0, opv2 = '0, link = '0;
  logic        we = 1'b0, ds = 1'b0;
  logic [4:0]  waddr = '0;
  logic        mem_we, mem_ds, stall_req;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, hi_o, lo_o;
  int passed = 0, total = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [7:0] ops [19] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A,
                           8'h2B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19, 8'h1A, 8'h1B};

  ex_stage dut (
    .clk(clk), .rst(rst), .ex_aluop(aluop), .ex_alusel(alusel), .ex_opv1(opv1), .ex_opv2(opv2),
    .ex_we(we), .ex_waddr(waddr), .ex_link_addr(link), .ex_cur_in_delay_slot(ds),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_cur_in_delay_slot(mem_ds),
    .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit known(input logic [7:0] op);
    case (op)
      8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A, 8'h2B,
      8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19, 8'h1A, 8'h1B: return 1'b1;
`ifdef EX_MADD_EN
      8'hA6, 8'hA7, 8'hAA, 8'hAB: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      8'h24, 8'h25, 8'h26, 8'h27: return 3'd1;
      8'h7C, 8'h02, 8'h03: return 3'd2;
      8'h21, 8'h23, 8'h2A, 8'h2B: return 3'd3;
      8'h10, 8'h12: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_res(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] fill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    fill = b[31] ? ~(32'hFFFFFFFF >> a[4:0]) : 32'h0;
    case (op)
      8'h24: return a & b;
      8'h25: return a | b;
      8'h26: return a ^ b;
      8'h27: return ~(a | b);
      8'h7C: return b << a[4:0];
      8'h02: return b >> a[4:0];
      8'h03: return (b >> a[4:0]) | fill;
      8'h21: return 32'(sa + sb);
      8'h23: return 32'(sa - sb);
      8'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      8'h2B: return (longint'({32'b0, a}) < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      8'h10: return m_hi;
      8'h12: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_update(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      8'h11: m_hi = a;
      8'h13: m_lo = a;
      8'h18: {m_hi, m_lo} = 64'(sa * sb);
      8'h19: {m_hi, m_lo} = up;
      8'h1A: if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
             else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      8'h1B: if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
             else begin m_lo = a / b; m_hi = a % b; end
`ifdef EX_MADD_EN
      8'hA6: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
      8'hA7: {m_hi, m_lo} = {m_hi, m_lo} + up;
      8'hAA: {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
      8'hAB: {m_hi, m_lo} = {m_hi, m_lo} - up;
`endif
      default: ;
    endcase
  endtask

  task automatic step(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic w, input logic [2:0] sel, input string tag);
    logic [31:0] er;
    aluop = op; alusel = sel; opv1 = a; opv2 = b; we = w;
    waddr = 5'($urandom); ds = 1'($urandom); link = $urandom;
    er = (known(op) && sel >= 3'd1 && sel <= 3'd5) ? ((sel == 3'd5) ? link : f_res(op, a, b)) : 32'h0;
    @(negedge clk);
    chk({tag, " wdata"}, mem_wdata, er);
    chk({tag, " we"}, {31'b0, mem_we}, {31'b0, w & known(op)});
    chk({tag, " waddr"}, {27'b0, mem_waddr}, {27'b0, waddr});
    chk({tag, " ds"}, {31'b0, mem_ds}, {31'b0, ds});
    chk({tag, " stall"}, {31'b0, stall_req}, 32'h0);
    @(posedge clk); #1;
    m_update(op, a, b);
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic wel;
    n = 0; wel = 1'b0;
    aluop = op; alusel = 3'd0; opv1 = a; opv2 = b; we = 1'b1;
    @(negedge clk);
    while (stall_req && n < 40) begin
      n++;
      if (mem_we) wel = 1'b1;
      @(negedge clk);
    end
    chk({tag, " stall cycles"}, 32'(n), (b == 0) ? 32'd1 : 32'd33);
    chk({tag, " we in stall"}, {31'b0, wel}, 32'h0);
    @(posedge clk); #1;
    m_update(op, a, b);
    chk({tag, " hi"}, hi_o, m_hi);
    chk({tag, " lo"}, lo_o, m_lo);
  endtask

  initial begin
    we = 1'b1; waddr = 5'd9; ds = 1'b1; alusel = 3'd5; link = 32'h1234_5678; aluop = 8'h25;
    @(negedge clk);
    chk("rst we", {31'b0, mem_we}, 32'h0);
    chk("rst waddr", {27'b0, mem_waddr}, 32'h0);
    chk("rst wdata", mem_wdata, 32'h0);
    chk("rst ds", {31'b0, mem_ds}, 32'h0);
    chk("rst hi", hi_o, 32'h0);
    chk("rst lo", lo_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(8'h23, 32'd5, 32'd7, 1'b1, 3'd3, "subu");
    chk("subu const", mem_wdata, 32'hFFFFFFFE);
    step(8'h2A, 32'hFFFFFFFF, 32'd1, 1'b1, 3'd3, "slt");
    step(8'h2B, 32'hFFFFFFFF, 32'd1, 1'b0, 3'd3, "sltu");
    step(8'h03, 32'd4, 32'h80000000, 1'b1, 3'd2, "sra");
    step(8'h25, 32'h0F0F, 32'hF000, 1'b1, 3'd5, "link");
    step(8'h55, 32'h1, 32'h2, 1'b1, 3'd3, "unknown");
    step(8'h18, 32'hFFFFFFFE, 32'd3, 1'b0, 3'd0, "mult");
    chk("mult hi const", hi_o, 32'hFFFFFFFF);
    chk("mult lo const", lo_o, 32'hFFFFFFFA);
    step(8'h10, 32'h0, 32'h0, 1'b1, 3'd4, "mfhi");
    step(8'h12, 32'h0, 32'h0, 1'b1, 3'd4, "mflo");
    step(8'h11, 32'hCAFE_0001, 32'h0, 1'b0, 3'd0, "mthi");
    step(8'h10, 32'h0, 32'h0, 1'b1, 3'd4, "mfhi2");
    do_div(8'h1A, 32'hFFFFFFF9, 32'd2, "div");
    chk("div lo const", lo_o, 32'hFFFFFFFD);
    chk("div hi const", hi_o, 32'hFFFFFFFF);
    do_div(8'h1B, 32'h1234, 32'h0, "divu0");
    chk("divu0 hi const", hi_o, 32'h00001234);
    do_div(8'h1A, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    step(8'h11, 32'h0, 32'h0, 1'b0, 3'd0, "mthi0");
    step(8'h13, 32'h10, 32'h0, 1'b0, 3'd0, "mtlo10");
`ifdef EX_MADD_EN
    aluop = 8'hA7; alusel = 3'd0; opv1 = 32'd3; opv2 = 32'd4; we = 1'b1;
    @(negedge clk);
    chk("maddu stall1", {31'b0, stall_req}, 32'h1);
    chk("maddu we1", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("maddu stall2", {31'b0, stall_req}, 32'h0);
    chk("maddu we2", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    m_update(8'hA7, 32'd3, 32'd4);
    chk("maddu lo", lo_o, 32'h1C);
    chk("maddu hi", hi_o, 32'h0);
`else
    step(8'hA7, 32'd3, 32'd4, 1'b1, 3'd0, "maddu off");
    chk("maddu off lo", lo_o, 32'h10);
    chk("maddu off hi", hi_o, 32'h0);
`endif
    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 18)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op == 8'h1A || op == 8'h1B) begin
        if ($urandom_range(0, 5) == 0) b = 32'h0;
        do_div(op, a, b, "rnd div");
      end else step(op, a, b, 1'($urandom), sel_of(op), "rnd");
    end
    step(8'h11, 32'h1111_2222, 32'h0, 1'b0, 3'd0, "pre mthi");
    step(8'h13, 32'h3333_4444, 32'h0, 1'b0, 3'd0, "pre mtlo");
    aluop = 8'h1B; alusel = 3'd5; opv1 = 32'd100; opv2 = 32'd7; we = 1'b1; link = 32'hDEAD_BEEF;
    repeat (11) @(posedge clk);
    #2;
    chk("mid div stall", {31'b0, stall_req}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort stall", {31'b0, stall_req}, 32'h0);
    chk("abort hi", hi_o, 32'h0);
    chk("abort lo", lo_o, 32'h0);
    chk("abort we", {31'b0, mem_we}, 32'h0);
    chk("abort wdata", mem_wdata, 32'h0);
    m_hi = '0; m_lo = '0;
    aluop = 8'h00; alusel = 3'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(8'h12, 32'h0, 32'h0, 1'b1, 3'd4, "mflo after rst");
    step(8'h10, 32'h0, 32'h0, 1'b1, 3'd4, "mfhi after rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its ex_* outputs.
- Computes ALU, shift, move and link results and drives them to the EX/MEM register.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration radix-2 divider FSM.
- Raises stall_req to the pipeline controller while a multi-cycle op is in flight.

Parameters:
- DIV_CYCLES, 32, divider iteration count; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_aluop  in  8  operation code from ID/EX.
- ex_alusel  in  3  result class: 000 NOP, 001 LOGIC, 010 SHIFT, 011 ARITH, 100 MOVE, 101 LINK.
- ex_opv1  in  32  operand 1. For shifts, bits [4:0] give the shift amount.
- ex_opv2  in  32  operand 2. For shifts, this is the value shifted.
- ex_we  in  1  GPR write request.
- ex_waddr  in  5  GPR destination.
- ex_link_addr  in  32  return address for LINK class.
- ex_cur_in_delay_slot  in  1  passed through to mem_cur_in_delay_slot.
- mem_we  out  1  GPR write enable to EX/MEM.
- mem_waddr  out  5  GPR destination to EX/MEM.
- mem_wdata  out  32  GPR write data to EX/MEM.
- mem_cur_in_delay_slot  out  1  delay-slot flag to EX/MEM.
- stall_req  out  1  request to hold PC, IF/ID and ID/EX.
- hi_o  out  32  current HI register.
- lo_o  out  32  current LO register.

Behaviour:
- Aluop codes:
  - AND 24, OR 25, XOR 26, NOR 27
  - SLL 7C, SRL 02, SRA 03
  - ADDU 21, SUBU 23, SLT 2A, SLTU 2B
  - MFHI 10, MTHI 11, MFLO 12, MTLO 13
  - MULT 18, MULTU 19, DIV 1A, DIVU 1B
  - All values are hex.
- Result path (combinational):
  - mem_wdata is selected by ex_alusel. MOVE selects HI or LO; LINK selects ex_link_addr.
  - Any unknown class or aluop gives mem_wdata 0.
- Write enable:
  - mem_we = ex_we, except it is forced to 0 for unknown aluops and while stall_req=1.
  - mem_waddr and mem_cur_in_delay_slot are passthroughs.
- Arithmetic rules:
  - ADDU/SUBU use 32-bit wrap; no overflow trap.
  - SLT compares signed; SLTU compares unsigned.
  - SRA sign-fills.
- HI/LO updates (on the clock edge, in the cycle the op is in EX with stall_req=0):
  - MTHI writes HI=opv1; MTLO writes LO=opv1.
  - MULT/MULTU write {HI,LO} = 64-bit product (signed or unsigned). Single cycle, no stall.
  - MFHI/MFLO read the registered value. A write in the same cycle is not visible until the next cycle.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: on DIV/DIVU, latch operands (abs values if signed), clear the counter, and assert stall_req.
    - Divisor zero: go to DONE.
    - Otherwise: go to BUSY.
  - BUSY: one shift-subtract iteration per cycle, stall_req=1. After 32 iterations go to DONE.
  - DONE: stall_req=0. On the edge, write HI=remainder and LO=quotient, then return to IDLE.
  - Signed fix-up: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: LO=FFFFFFFF, HI=opv1.
  - Latency: normal divide has stall_req high 33 cycles and occupies EX 34 cycles. Divide by zero stalls 1 cycle.
  - Operands are held stable by the controller during a stall. The FSM does not re-sample them in BUSY.
- Reset (rst=0, asynchronous):
  - HI=0, LO=0, FSM to IDLE, counter and divider datapath cleared.
  - mem_we=0, mem_waddr=0, mem_wdata=0, mem_cur_in_delay_slot=0, stall_req=0.
  - A reset mid-divide aborts the divide with no HI/LO write.
- A non-divide aluop arriving in IDLE never starts the FSM.

Optional Feature:
- Macro: EX_MADD_EN.
- Defined: adds MADD A6, MADDU A7, MSUB AA, MSUBU AB (hex).
  - Cycle 1: product into a 64-bit temp register, stall_req=1.
  - Cycle 2: stall_req=0; {HI,LO} ± temp written on the edge.
  - These ops use the same FSM with an extra state ACC, and never write the GPR.
- Undefined: these codes are unknown aluops. mem_we=0, no stall, no HI/LO change.

Test Plan:
- Reset sequencing:
  - Stimulus: drive rst=0 mid-DIVU (counter=10), then release.
  - Response: stall_req=0 immediately, hi_o=lo_o=0, FSM idle. A following MFLO gives mem_wdata 0.
- ALU and shift:
  - Stimulus: SUBU 5,7 -> FFFFFFFE. SLT FFFFFFFF,1 -> 1. SLTU FFFFFFFF,1 -> 0. SRA 4,80000000 -> F8000000.
  - Response: each with mem_we=ex_we.
- Multiply:
  - Stimulus: MULT FFFFFFFE,3, then MFHI, then MFLO.
  - Response: HI=FFFFFFFF, LO=FFFFFFFA. MFHI the following cycle returns FFFFFFFF.
- Signed divide:
  - Stimulus: DIV FFFFFFF9,2 (-7/2).
  - Response: stall_req high exactly 33 cycles. Then LO=FFFFFFFD, HI=FFFFFFFF. mem_we=0 throughout the stall.
- Divide by zero:
  - Stimulus: DIVU 1234,0.
  - Response: stall_req high 1 cycle. LO=FFFFFFFF, HI=00001234.
- EX_MADD_EN:
  - Stimulus: with HI/LO=0/10, MADDU 3,4.
  - Response: 1 stall cycle, then LO=1C, HI=0. With the macro undefined: no stall, HI/LO unchanged.
